// File: rtl/cpu_ram_debug.sv
// CPU data RAM with a req/ack debug port, an optional clear sweep after reset
// and address watchpoints that request a CPU halt.
module cpu_ram_debug #(
    parameter int unsigned           DATA_WIDTH    = 4,
    parameter int unsigned           ADDR_WIDTH    = 12,
    parameter int unsigned           DEPTH         = 4096,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter int unsigned           N_WATCH       = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          memory_write_en,
    input  logic [ADDR_WIDTH-1:0]         memory_addr,
    input  logic [DATA_WIDTH-1:0]         memory_write_data,
    output logic [DATA_WIDTH-1:0]         memory_read_data,
    input  logic                          dbg_req,
    input  logic                          dbg_we,
    input  logic [ADDR_WIDTH-1:0]         dbg_addr,
    input  logic [DATA_WIDTH-1:0]         dbg_wdata,
    output logic                          dbg_ack,
    output logic [DATA_WIDTH-1:0]         dbg_rdata,
    input  logic [N_WATCH*ADDR_WIDTH-1:0] wp_addr,
    input  logic [N_WATCH*2-1:0]          wp_mode,
    input  logic                          wp_clear,
    output logic [N_WATCH-1:0]            wp_hit,
    output logic                          halt_req,
    output logic                          init_busy
);

    localparam int unsigned           IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0]       LastIdx  = IdxW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {ClrIdle, ClrSweep} clr_state_e;
    typedef enum logic [1:0] {DbgIdle, DbgAck, DbgBlocked} dbg_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_e            clr_state_q, clr_state_d;
    logic [IdxW-1:0]       clr_idx_q, clr_idx_d;
    logic                  clr_last;

    dbg_state_e            dbg_state_q, dbg_state_d;
    logic                  dbg_go;

    logic [DATA_WIDTH-1:0] rd_data_q, dbg_rdata_q;
    logic [N_WATCH-1:0]    wp_match, wp_hit_q, wp_hit_d;

    logic                  cpu_in_range, dbg_in_range;
    logic [IdxW-1:0]       cpu_idx, dbg_idx;

    assign cpu_in_range = {1'b0, memory_addr} < DepthLim;
    assign dbg_in_range = {1'b0, dbg_addr} < DepthLim;
    assign cpu_idx      = memory_addr[IdxW-1:0];
    assign dbg_idx      = dbg_addr[IdxW-1:0];

    // ---------------- Clear sweep FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (INIT_ON_RESET) begin
                clr_state_q <= ClrSweep;
            end else begin
                clr_state_q <= ClrIdle;
            end
            clr_idx_q <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_idx_q   <= clr_idx_d;
        end
    end

    always_comb begin
        clr_state_d = clr_state_q;
        clr_idx_d   = clr_idx_q;
        unique case (clr_state_q)
            ClrSweep: begin
                if (clr_idx_q == LastIdx) begin
                    clr_state_d = ClrIdle;
                    clr_idx_d   = '0;
                end else begin
                    clr_idx_d = clr_idx_q + IdxW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        init_busy = (clr_state_q == ClrSweep);
        clr_last  = init_busy && (clr_idx_q == LastIdx);
    end

    // ---------------- Debug port FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (INIT_ON_RESET) begin
                dbg_state_q <= DbgBlocked;
            end else begin
                dbg_state_q <= DbgIdle;
            end
        end else begin
            dbg_state_q <= dbg_state_d;
        end
    end

    always_comb begin
        dbg_state_d = dbg_state_q;
        unique case (dbg_state_q)
            DbgIdle: begin
                if (init_busy) begin
                    dbg_state_d = DbgBlocked;
                end else if (dbg_req) begin
                    dbg_state_d = DbgAck;
                end
            end
            DbgAck: dbg_state_d = DbgIdle;
            // Leave at the edge that writes the last word so the first free cycle can serve.
            DbgBlocked: begin
                if (clr_last) begin
                    dbg_state_d = DbgIdle;
                end
            end
            default: dbg_state_d = DbgIdle;
        endcase
    end

    always_comb begin
        dbg_go  = (dbg_state_q == DbgIdle) && dbg_req && !init_busy;
        dbg_ack = (dbg_state_q == DbgAck);
    end

    // ---------------- Watchpoints ----------------
    always_comb begin
        wp_match = '0;
        for (int i = 0; i < N_WATCH; i++) begin
            wp_match[i] = (memory_addr == wp_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                          (memory_write_en ? wp_mode[2*i+1] : wp_mode[2*i]);
        end
        wp_hit_d = wp_clear ? wp_match : (wp_hit_q | wp_match);
    end

    // ---------------- Storage ----------------
    // Later assignments win: sweep, then debug, then CPU.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_idx_q] <= INIT_VALUE;
        end
        if (dbg_go && dbg_we && dbg_in_range) begin
            mem[dbg_idx] <= dbg_wdata;
        end
        if (memory_write_en && cpu_in_range) begin
            mem[cpu_idx] <= memory_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q   <= '0;
            dbg_rdata_q <= '0;
            wp_hit_q    <= '0;
        end else begin
            if (!memory_write_en) begin
                rd_data_q <= cpu_in_range ? mem[cpu_idx] : '0;
            end
            if (dbg_go && !dbg_we) begin
                dbg_rdata_q <= dbg_in_range ? mem[dbg_idx] : '0;
            end
            wp_hit_q <= wp_hit_d;
        end
    end

    assign memory_read_data = rd_data_q;
    assign dbg_rdata        = dbg_rdata_q;
    assign wp_hit           = wp_hit_q;
    assign halt_req         = |wp_hit_q;

endmodule

// File: tb/tb_cpu_ram_debug.sv
// Bench for cpu_ram_debug: directed stimulus, a transaction-level memory model
// checked every cycle, and literal expectations for the key scenarios.
module tb_cpu_ram_debug;

    localparam int DW    = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;
    localparam int NW    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          memory_write_en;
    logic [AW-1:0] memory_addr;
    logic [DW-1:0] memory_write_data;
    logic [DW-1:0] memory_read_data;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [NW*AW-1:0] wp_addr;
    logic [NW*2-1:0]  wp_mode;
    logic          wp_clear;
    logic [NW-1:0] wp_hit;
    logic          halt_req, init_busy;

    int vectors = 0;
    int miscompares = 0;

    cpu_ram_debug #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_ON_RESET(1'b1),
        .INIT_VALUE(4'h0), .N_WATCH(NW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .memory_write_en(memory_write_en), .memory_addr(memory_addr),
        .memory_write_data(memory_write_data), .memory_read_data(memory_read_data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .wp_addr(wp_addr), .wp_mode(wp_mode), .wp_clear(wp_clear), .wp_hit(wp_hit),
        .halt_req(halt_req), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] e_rd, e_drd;
    bit            e_rd_ok, e_drd_ok, e_ack, e_busy;
    logic [NW-1:0] e_hit;
    int            sweep_k;

    task automatic model_reset();
        e_rd = '0; e_rd_ok = 1; e_drd = '0; e_drd_ok = 1;
        e_ack = 0; e_hit = '0; sweep_k = 0; e_busy = 1;
    endtask

    task automatic model_step();
        bit            go, busy_now;
        logic [NW-1:0] hits;
        busy_now = e_busy;
        // An access is served when the port is free, not sweeping and not in its ack cycle.
        go = dbg_req && !busy_now && !e_ack;
        if (!memory_write_en) begin
            if (memory_addr < DEPTH) begin
                e_rd = m_mem[memory_addr]; e_rd_ok = m_known[memory_addr];
            end else begin
                e_rd = '0; e_rd_ok = 1;
            end
        end
        if (go && !dbg_we) begin
            if (dbg_addr < DEPTH) begin
                e_drd = m_mem[dbg_addr]; e_drd_ok = m_known[dbg_addr];
            end else begin
                e_drd = '0; e_drd_ok = 1;
            end
        end
        e_ack = go;
        hits = '0;
        for (int i = 0; i < NW; i++) begin
            if (memory_addr == wp_addr[i*AW +: AW] &&
                (memory_write_en ? wp_mode[2*i+1] : wp_mode[2*i])) hits[i] = 1'b1;
        end
        e_hit = wp_clear ? hits : (e_hit | hits);
        if (busy_now) begin
            m_mem[sweep_k] = 4'h0; m_known[sweep_k] = 1; sweep_k++;
        end
        if (go && dbg_we && dbg_addr < DEPTH) begin
            m_mem[dbg_addr] = dbg_wdata; m_known[dbg_addr] = 1;
        end
        if (memory_write_en && memory_addr < DEPTH) begin
            m_mem[memory_addr] = memory_write_data; m_known[memory_addr] = 1;
        end
        e_busy = sweep_k < DEPTH;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("init_busy", init_busy, e_busy);
            chk("dbg_ack", dbg_ack, e_ack);
            chk("wp_hit", wp_hit, e_hit);
            chk("halt_req", halt_req, |e_hit);
            if (e_rd_ok) chk("memory_read_data", memory_read_data, e_rd);
            if (e_drd_ok) chk("dbg_rdata", dbg_rdata, e_drd);
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        memory_write_en = 0; memory_addr = '0; memory_write_data = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; wp_clear = 0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs(); memory_write_en = 1; memory_addr = a; memory_write_data = d; tick();
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a);
        idle_inputs(); memory_addr = a; tick();
    endtask

    // One debug access followed by the mandatory ack cycle.
    task automatic dbg_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs(); dbg_req = 1; dbg_we = w; dbg_addr = a; dbg_wdata = d; tick();
        chk("dbg_op ack", dbg_ack, 1);
        idle_inputs(); tick();
    endtask

    // Runs while the sweep is busy; at iteration poke the CPU writes word poke.
    task automatic run_sweep(input int max_cyc, input int poke, input logic [DW-1:0] val,
                             output int n);
        n = 0;
        while (init_busy && n < max_cyc) begin
            memory_write_en = (n == poke);
            memory_addr = (n == poke) ? AW'(poke) : '0;
            memory_write_data = val;
            tick();
            n++;
        end
        memory_write_en = 0; memory_addr = '0;
    endtask

    initial begin
        int n;
        logic [5:0] pat;
        idle_inputs();
        wp_addr = {12'h046, 12'h4F0};
        wp_mode = {2'b10, 2'b01};
        repeat (3) tick();
        chk("reset busy", init_busy, 1);
        chk("reset rdata", memory_read_data, 0);
        chk("reset hit", wp_hit, 0);

        // 1: sweep length, held debug read is served only afterwards
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'hFFF;
        reset_n = 1;
        run_sweep(5000, -1, 4'h0, n);
        chk("sweep cycles", n, 4096);
        tick();
        chk("held req ack", dbg_ack, 1);
        chk("read 0xFFF", dbg_rdata, 4'h0);
        idle_inputs(); tick();

        // 2: CPU write/read, hold during write, read watchpoint on channel 0
        cpu_wr(12'h4F0, 4'hC);
        chk("no hit on write", wp_hit, 2'b00);
        cpu_rd(12'h4F0);
        chk("cpu read 0x4F0", memory_read_data, 4'hC);
        chk("read wp hit", wp_hit, 2'b01);
        cpu_wr(12'h4F1, 4'h1);
        chk("rdata held", memory_read_data, 4'hC);
        idle_inputs(); wp_clear = 1; tick();
        chk("clear ch0", wp_hit, 2'b00);

        // 3: debug write then CPU read, back-to-back debug reads
        dbg_op(1, 12'h044, 4'hD);
        cpu_rd(12'h044);
        chk("cpu read 0x044", memory_read_data, 4'hD);
        idle_inputs(); dbg_req = 1; dbg_addr = 12'h044;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat = {pat[4:0], dbg_ack};
        end
        chk("ack pattern", pat, 6'b101010);
        chk("b2b rdata", dbg_rdata, 4'hD);
        idle_inputs(); tick();

        // 4: same-cycle collisions
        idle_inputs();
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h100; dbg_wdata = 4'h9;
        memory_write_en = 1; memory_addr = 12'h100; memory_write_data = 4'h3;
        tick();
        chk("collide ack", dbg_ack, 1);
        idle_inputs(); tick();
        dbg_op(0, 12'h100, 4'h0);
        chk("cpu wins", dbg_rdata, 4'h3);
        dbg_op(1, 12'h101, 4'h5);
        idle_inputs();
        dbg_req = 1; dbg_addr = 12'h101;
        memory_write_en = 1; memory_addr = 12'h101; memory_write_data = 4'h7;
        tick();
        chk("read-before-write", dbg_rdata, 4'h5);
        idle_inputs(); tick();
        cpu_rd(12'h101);
        chk("cpu write landed", memory_read_data, 4'h7);

        // 5: write-only watchpoint on channel 1
        cpu_rd(12'h046);
        chk("read no hit", wp_hit, 2'b00);
        cpu_wr(12'h046, 4'h2);
        chk("write hit", wp_hit, 2'b10);
        chk("halt set", halt_req, 1);
        idle_inputs(); wp_clear = 1; tick();
        chk("hit cleared", wp_hit, 2'b00);
        chk("halt cleared", halt_req, 0);
        idle_inputs(); wp_clear = 1;
        memory_write_en = 1; memory_addr = 12'h046; memory_write_data = 4'h4;
        tick();
        chk("match beats clear", wp_hit, 2'b10);
        idle_inputs(); tick();

        // 6: abort the sweep at word 100, then a full restart
        #2 reset_n = 0;
        repeat (2) tick();
        chk("rst hit", wp_hit, 2'b00);
        reset_n = 1;
        run_sweep(100, 50, 4'hA, n);
        chk("partial sweep", n, 100);
        #2 reset_n = 0;
        tick();
        chk("busy in reset", init_busy, 1);
        tick();
        reset_n = 1;
        run_sweep(5000, 30, 4'h6, n);
        chk("restart cycles", n, 4096);
        dbg_op(0, 12'd50, 4'h0);
        chk("word 50 re-cleared", dbg_rdata, 4'h0);
        dbg_op(0, 12'd30, 4'h0);
        chk("cpu beats sweep", dbg_rdata, 4'h6);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
